// File: rtl/cpu86_exec_trace_emitter.sv
// cpu86_exec_trace_emitter
// Exec-stage validation trace producer. Shadows the eight GPRs and FLAGS from
// the exec writeback ports, snapshots the architectural state plus the
// instruction identity on every retire, queues the snapshots in a small FIFO
// and presents the FIFO head on the registered vld_* record bus.
// The FIFO occupancy (EMPTY / PARTIAL / FULL) is the only state sequencing.
// ENABLE=0 removes all logic and ties every output to its reset value.

module cpu86_exec_trace_emitter #(
    parameter bit ENABLE = 1'b1,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [2:0]  wb_dreg,
    input  logic [1:0]  wb_mask,
    input  logic [15:0] wb_data,
    input  logic        fl_valid,
    input  logic [15:0] fl_data,
    input  logic        ret_valid,
    input  logic [4:0]  ret_op,
    input  logic [3:0]  ret_code,
    input  logic [15:0] ret_cs,
    input  logic [15:0] ret_ip,
    input  logic [3:0]  ret_sreg,
    input  logic [3:0]  ret_dreg,
    input  logic        ret_branch_taken,
    input  logic        vld_ready,
    output logic        vld_valid,
    output logic [4:0]  vld_op,
    output logic [3:0]  vld_code,
    output logic [15:0] vld_cs,
    output logic [15:0] vld_ip,
    output logic [15:0] vld_ax,
    output logic [15:0] vld_bx,
    output logic [15:0] vld_cx,
    output logic [15:0] vld_dx,
    output logic [15:0] vld_bp,
    output logic [15:0] vld_sp,
    output logic [15:0] vld_si,
    output logic [15:0] vld_di,
    output logic [15:0] vld_fl,
    output logic [3:0]  vld_sreg,
    output logic [3:0]  vld_dreg,
    output logic        vld_branch_taken,
    output logic [15:0] ovf_cnt,
    output logic        busy
);

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  code;
        logic [15:0] cs;
        logic [15:0] ip;
        logic [15:0] ax;
        logic [15:0] bx;
        logic [15:0] cx;
        logic [15:0] dx;
        logic [15:0] bp;
        logic [15:0] sp;
        logic [15:0] si;
        logic [15:0] di;
        logic [15:0] fl;
        logic [3:0]  sreg;
        logic [3:0]  dreg;
        logic        br;
    } rec_t;

    generate
        if (ENABLE) begin : g_on
            localparam int AW = $clog2(DEPTH);
            localparam int CW = AW + 1;

            logic [15:0]   gpr_r     [8];
            logic [15:0]   gpr_byp_s [8];
            logic [15:0]   fl_r;
            logic [15:0]   fl_byp_s;
            rec_t          cap_s;
            rec_t          head_nx_s;
            rec_t          mem_r [DEPTH];
            rec_t          out_r;
            logic [AW-1:0] rd_ptr_r;
            logic [AW-1:0] wr_ptr_r;
            logic [AW-1:0] rd_nx_s;
            logic [CW-1:0] count_r;
            logic [CW-1:0] after_pop_s;
            logic [CW-1:0] count_nx_s;
            logic          full_s;
            logic          pop_s;
            logic          push_s;
            logic          drop_s;
            logic          valid_r;
            logic [15:0]   ovf_r;

            // Same-cycle writeback bypass: shadow state as it stands after this cycle's writes.
            always_comb begin
                for (int i = 0; i < 8; i++) begin
                    gpr_byp_s[i] = gpr_r[i];
                    if (wb_valid && (wb_dreg == 3'(i))) begin
                        if (wb_mask[0]) gpr_byp_s[i][7:0] = wb_data[7:0];
                        else            gpr_byp_s[i][7:0] = gpr_r[i][7:0];
                        if (wb_mask[1]) gpr_byp_s[i][15:8] = wb_data[15:8];
                        else            gpr_byp_s[i][15:8] = gpr_r[i][15:8];
                    end else begin
                        gpr_byp_s[i] = gpr_r[i];
                    end
                end
                if (fl_valid) fl_byp_s = fl_data;
                else          fl_byp_s = fl_r;
            end

            // Assemble the retire snapshot from the bypassed shadow and instruction identity.
            always_comb begin
                cap_s.op   = ret_op;
                cap_s.code = ret_code;
                cap_s.cs   = ret_cs;
                cap_s.ip   = ret_ip;
                cap_s.ax   = gpr_byp_s[0];
                cap_s.cx   = gpr_byp_s[1];
                cap_s.dx   = gpr_byp_s[2];
                cap_s.bx   = gpr_byp_s[3];
                cap_s.sp   = gpr_byp_s[4];
                cap_s.bp   = gpr_byp_s[5];
                cap_s.si   = gpr_byp_s[6];
                cap_s.di   = gpr_byp_s[7];
                cap_s.fl   = fl_byp_s;
                cap_s.sreg = ret_sreg;
                cap_s.dreg = ret_dreg;
                cap_s.br   = ret_branch_taken;
            end

            // FIFO control: a full FIFO still accepts a push when the head pops in the same cycle.
            always_comb begin
                full_s      = (count_r == CW'(DEPTH));
                pop_s       = (count_r != {CW{1'b0}}) && vld_ready;
                push_s      = ret_valid && (!full_s || pop_s);
                drop_s      = ret_valid && full_s && !pop_s;
                after_pop_s = count_r - CW'(pop_s);
                count_nx_s  = after_pop_s + CW'(push_s);
                rd_nx_s     = rd_ptr_r + AW'(pop_s);
                if (push_s && (after_pop_s == {CW{1'b0}})) head_nx_s = cap_s;
                else                                        head_nx_s = mem_r[rd_nx_s];
            end

            // Shadow register file and FLAGS follow the bypassed values.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < 8; i++) gpr_r[i] <= 16'h0000;
                    fl_r <= 16'h0002;
                end else begin
                    for (int i = 0; i < 8; i++) gpr_r[i] <= gpr_byp_s[i];
                    fl_r <= fl_byp_s;
                end
            end

            // Snapshot storage, pointers, occupancy and saturating drop counter.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
                    rd_ptr_r <= {AW{1'b0}};
                    wr_ptr_r <= {AW{1'b0}};
                    count_r  <= {CW{1'b0}};
                    ovf_r    <= 16'h0000;
                end else begin
                    if (push_s) begin
                        mem_r[wr_ptr_r] <= cap_s;
                        wr_ptr_r        <= wr_ptr_r + AW'(1);
                    end
                    rd_ptr_r <= rd_nx_s;
                    count_r  <= count_nx_s;
                    if (drop_s && (ovf_r != 16'hFFFF)) ovf_r <= ovf_r + 16'h0001;
                end
            end

            // Registered record output: reloads the next head, holds while empty.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    valid_r <= 1'b0;
                    out_r   <= '0;
                end else begin
                    valid_r <= (count_nx_s != {CW{1'b0}});
                    if (count_nx_s != {CW{1'b0}}) out_r <= head_nx_s;
                    else                          out_r <= out_r;
                end
            end

            assign vld_valid        = valid_r;
            assign busy             = valid_r;
            assign ovf_cnt          = ovf_r;
            assign vld_op           = out_r.op;
            assign vld_code         = out_r.code;
            assign vld_cs           = out_r.cs;
            assign vld_ip           = out_r.ip;
            assign vld_ax           = out_r.ax;
            assign vld_bx           = out_r.bx;
            assign vld_cx           = out_r.cx;
            assign vld_dx           = out_r.dx;
            assign vld_bp           = out_r.bp;
            assign vld_sp           = out_r.sp;
            assign vld_si           = out_r.si;
            assign vld_di           = out_r.di;
            assign vld_fl           = out_r.fl;
            assign vld_sreg         = out_r.sreg;
            assign vld_dreg         = out_r.dreg;
            assign vld_branch_taken = out_r.br;
        end else begin : g_off
            assign vld_valid        = 1'b0;
            assign busy             = 1'b0;
            assign ovf_cnt          = 16'h0000;
            assign vld_op           = 5'h00;
            assign vld_code         = 4'h0;
            assign vld_cs           = 16'h0000;
            assign vld_ip           = 16'h0000;
            assign vld_ax           = 16'h0000;
            assign vld_bx           = 16'h0000;
            assign vld_cx           = 16'h0000;
            assign vld_dx           = 16'h0000;
            assign vld_bp           = 16'h0000;
            assign vld_sp           = 16'h0000;
            assign vld_si           = 16'h0000;
            assign vld_di           = 16'h0000;
            assign vld_fl           = 16'h0000;
            assign vld_sreg         = 4'h0;
            assign vld_dreg         = 4'h0;
            assign vld_branch_taken = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_cpu86_exec_trace_emitter.sv
// Testbench for cpu86_exec_trace_emitter: table-driven vectors, directed
// multi-cycle sequences and randomized traffic, all checked against a
// queue-based reference model of shadow state, FIFO and drop counter.

module tb_cpu86_exec_trace_emitter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        resetn;
    logic        wb_valid;
    logic [2:0]  wb_dreg;
    logic [1:0]  wb_mask;
    logic [15:0] wb_data;
    logic        fl_valid;
    logic [15:0] fl_data;
    logic        ret_valid;
    logic [4:0]  ret_op;
    logic [3:0]  ret_code;
    logic [15:0] ret_cs;
    logic [15:0] ret_ip;
    logic [3:0]  ret_sreg;
    logic [3:0]  ret_dreg;
    logic        ret_branch_taken;
    logic        vld_ready;
    logic        vld_valid;
    logic [4:0]  vld_op;
    logic [3:0]  vld_code;
    logic [15:0] vld_cs, vld_ip, vld_ax, vld_bx, vld_cx, vld_dx;
    logic [15:0] vld_bp, vld_sp, vld_si, vld_di, vld_fl;
    logic [3:0]  vld_sreg, vld_dreg;
    logic        vld_branch_taken;
    logic [15:0] ovf_cnt;
    logic        busy;

    cpu86_exec_trace_emitter #(.ENABLE(1'b1), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .wb_valid(wb_valid), .wb_dreg(wb_dreg), .wb_mask(wb_mask), .wb_data(wb_data),
        .fl_valid(fl_valid), .fl_data(fl_data),
        .ret_valid(ret_valid), .ret_op(ret_op), .ret_code(ret_code), .ret_cs(ret_cs),
        .ret_ip(ret_ip), .ret_sreg(ret_sreg), .ret_dreg(ret_dreg),
        .ret_branch_taken(ret_branch_taken), .vld_ready(vld_ready),
        .vld_valid(vld_valid), .vld_op(vld_op), .vld_code(vld_code), .vld_cs(vld_cs),
        .vld_ip(vld_ip), .vld_ax(vld_ax), .vld_bx(vld_bx), .vld_cx(vld_cx), .vld_dx(vld_dx),
        .vld_bp(vld_bp), .vld_sp(vld_sp), .vld_si(vld_si), .vld_di(vld_di), .vld_fl(vld_fl),
        .vld_sreg(vld_sreg), .vld_dreg(vld_dreg), .vld_branch_taken(vld_branch_taken),
        .ovf_cnt(ovf_cnt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record view indexed by GPR number: 0 AX,1 CX,2 DX,3 BX,4 SP,5 BP,6 SI,7 DI.
    typedef struct packed {
        logic [4:0]       op;
        logic [3:0]       code;
        logic [15:0]      cs;
        logic [15:0]      ip;
        logic [7:0][15:0] r;
        logic [15:0]      fl;
        logic [3:0]       sreg;
        logic [3:0]       dreg;
        logic             br;
    } trec_t;

    typedef struct {
        logic        wv;
        logic [2:0]  wd;
        logic [1:0]  wm;
        logic [15:0] wdat;
        logic        fv;
        logic [15:0] fdat;
        logic        rv;
        logic [15:0] rip;
        logic        e_valid;
        logic [2:0]  e_reg;
        logic [15:0] e_val;
        logic [15:0] e_ip;
        logic [15:0] e_fl;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [15:0] m_gpr [8];
    logic [15:0] m_fl;
    trec_t       m_q [$];
    int          m_ovf;
    trec_t       m_last;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic trec_t dut_rec();
        trec_t d;
        d.op = vld_op; d.code = vld_code; d.cs = vld_cs; d.ip = vld_ip;
        d.r[0] = vld_ax; d.r[1] = vld_cx; d.r[2] = vld_dx; d.r[3] = vld_bx;
        d.r[4] = vld_sp; d.r[5] = vld_bp; d.r[6] = vld_si; d.r[7] = vld_di;
        d.fl = vld_fl; d.sreg = vld_sreg; d.dreg = vld_dreg; d.br = vld_branch_taken;
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_gpr[i] = 16'h0000;
        m_fl = 16'h0002;
        m_q.delete();
        m_ovf = 0;
        m_last = '0;
    endtask

    // Applies the spec rules for one clock edge using the inputs currently driven.
    task automatic model_step();
        trec_t s;
        bit pop;
        pop = (m_q.size() > 0) && vld_ready;
        if (wb_valid) begin
            if (wb_mask[0]) m_gpr[wb_dreg][7:0]  = wb_data[7:0];
            if (wb_mask[1]) m_gpr[wb_dreg][15:8] = wb_data[15:8];
        end
        if (fl_valid) m_fl = fl_data;
        if (pop) void'(m_q.pop_front());
        if (ret_valid) begin
            s.op = ret_op; s.code = ret_code; s.cs = ret_cs; s.ip = ret_ip;
            for (int i = 0; i < 8; i++) s.r[i] = m_gpr[i];
            s.fl = m_fl; s.sreg = ret_sreg; s.dreg = ret_dreg; s.br = ret_branch_taken;
            if (m_q.size() < DEPTH) m_q.push_back(s);
            else if (m_ovf < 65535) m_ovf++;
        end
        if (m_q.size() > 0) m_last = m_q[0];
    endtask

    task automatic compare_model();
        chk("valid", 256'(vld_valid), 256'(m_q.size() != 0));
        chk("busy", 256'(busy), 256'(m_q.size() != 0));
        chk("ovf_cnt", 256'(ovf_cnt), 256'(m_ovf));
        chk("record", 256'(dut_rec()), 256'(m_last));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic set_idle(input logic rdy);
        wb_valid = 1'b0; wb_dreg = 3'd0; wb_mask = 2'b00; wb_data = 16'h0000;
        fl_valid = 1'b0; fl_data = 16'h0000;
        ret_valid = 1'b0; ret_op = 5'd0; ret_code = 4'd0; ret_cs = 16'h0000;
        ret_ip = 16'h0000; ret_sreg = 4'd0; ret_dreg = 4'd0; ret_branch_taken = 1'b0;
        vld_ready = rdy;
    endtask

    task automatic retire(input logic [15:0] ip);
        ret_valid = 1'b1;
        ret_ip = ip;
        cycle();
        ret_valid = 1'b0;
    endtask

    // Asynchronous reset applied between edges, released on a falling edge.
    task automatic do_reset();
        resetn = 1'b0;
        #2;
        model_reset();
        chk("rst_valid", 256'(vld_valid), 256'(1'b0));
        chk("rst_busy", 256'(busy), 256'(1'b0));
        @(negedge clk);
        resetn = 1'b1;
        set_idle(1'b1);
        cycle();
    endtask

    vec_t vt [10];
    trec_t cur;

    initial begin
        vt[0] = '{1'b1, 3'd0, 2'b11, 16'h1234, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b1, 3'd0, 16'h1234, 16'h0100, 16'h0002};
        vt[1] = '{1'b1, 3'd1, 2'b11, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h1234, 16'h0100, 16'h0002};
        vt[2] = '{1'b1, 3'd1, 2'b01, 16'h00AB, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd1, 16'h0000, 16'h0100, 16'h0002};
        vt[3] = '{1'b0, 3'd0, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0200, 1'b1, 3'd1, 16'hFFAB, 16'h0200, 16'h0002};
        vt[4] = '{1'b1, 3'd1, 2'b10, 16'h5600, 1'b0, 16'h0000, 1'b1, 16'h0201, 1'b1, 3'd1, 16'h56AB, 16'h0201, 16'h0002};
        vt[5] = '{1'b0, 3'd0, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0300, 1'b1, 3'd3, 16'h0000, 16'h0300, 16'h0002};
        vt[6] = '{1'b1, 3'd3, 2'b11, 16'h7777, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd3, 16'h0000, 16'h0300, 16'h0002};
        vt[7] = '{1'b0, 3'd0, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0301, 1'b1, 3'd3, 16'h7777, 16'h0301, 16'h0002};
        vt[8] = '{1'b1, 3'd2, 2'b00, 16'h1111, 1'b1, 16'hABCD, 1'b1, 16'h0302, 1'b1, 3'd2, 16'h0000, 16'h0302, 16'hABCD};
        vt[9] = '{1'b1, 3'd6, 2'b11, 16'hBEEF, 1'b1, 16'h0046, 1'b1, 16'h0303, 1'b1, 3'd6, 16'hBEEF, 16'h0303, 16'h0046};

        set_idle(1'b1);
        resetn = 1'b0;
        model_reset();
        #12;
        compare_model();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors: writeback masks, same-cycle bypass, N+1 exclusion.
        for (int k = 0; k < 10; k++) begin
            wb_valid = vt[k].wv; wb_dreg = vt[k].wd; wb_mask = vt[k].wm; wb_data = vt[k].wdat;
            fl_valid = vt[k].fv; fl_data = vt[k].fdat;
            ret_valid = vt[k].rv; ret_ip = vt[k].rip;
            cycle();
            cur = dut_rec();
            chk($sformatf("vec%0d_valid", k), 256'(vld_valid), 256'(vt[k].e_valid));
            chk($sformatf("vec%0d_reg", k), 256'(cur.r[vt[k].e_reg]), 256'(vt[k].e_val));
            chk($sformatf("vec%0d_ip", k), 256'(vld_ip), 256'(vt[k].e_ip));
            chk($sformatf("vec%0d_fl", k), 256'(vld_fl), 256'(vt[k].e_fl));
        end
        set_idle(1'b1);
        cycle();

        // Overflow: four queued records with the consumer stalled, a fifth is dropped.
        do_reset();
        vld_ready = 1'b0;
        for (int k = 1; k <= 4; k++) retire(16'(k));
        chk("ovf_head_ip", 256'(vld_ip), 256'(16'h0001));
        retire(16'h0005);
        chk("ovf_cnt_one", 256'(ovf_cnt), 256'(16'h0001));
        chk("ovf_head_kept", 256'(vld_ip), 256'(16'h0001));
        vld_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            cycle();
            chk("drain_ip", 256'(vld_ip), 256'(k));
        end
        cycle();
        chk("drain_busy", 256'(busy), 256'(1'b0));
        chk("drain_valid", 256'(vld_valid), 256'(1'b0));

        // Full FIFO with a same-cycle pop and push: nothing dropped, order preserved.
        vld_ready = 1'b0;
        for (int k = 0; k < 4; k++) retire(16'h0010 + 16'(k));
        vld_ready = 1'b1;
        for (int k = 4; k < 8; k++) retire(16'h0010 + 16'(k));
        chk("full_pop_ovf", 256'(ovf_cnt), 256'(16'h0001));
        for (int k = 5; k < 8; k++) begin
            cycle();
            chk("full_pop_ip", 256'(vld_ip), 256'(16'h0010 + 16'(k)));
        end
        cycle();
        chk("full_pop_empty", 256'(busy), 256'(1'b0));

        // Reset mid-stream with three records queued.
        vld_ready = 1'b0;
        for (int k = 0; k < 3; k++) retire(16'h0040 + 16'(k));
        chk("pre_rst_busy", 256'(busy), 256'(1'b1));
        do_reset();
        for (int k = 0; k < 3; k++) cycle();
        chk("post_rst_ip", 256'(vld_ip), 256'(16'h0000));

        // Randomized traffic against the model, with a stall-heavy second half.
        for (int n = 0; n < 400; n++) begin
            wb_valid = 1'($urandom_range(0, 1));
            wb_dreg  = 3'($urandom);
            wb_mask  = 2'($urandom);
            wb_data  = 16'($urandom);
            fl_valid = ($urandom_range(0, 9) < 3);
            fl_data  = 16'($urandom);
            ret_valid = 1'($urandom_range(0, 1));
            ret_op   = 5'($urandom);
            ret_code = 4'($urandom);
            ret_cs   = 16'($urandom);
            ret_ip   = 16'($urandom);
            ret_sreg = 4'($urandom);
            ret_dreg = 4'($urandom);
            ret_branch_taken = 1'($urandom);
            vld_ready = (n < 200) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            cycle();
        end
        set_idle(1'b1);
        for (int k = 0; k < DEPTH + 1; k++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
